// File: rtl/layer_seq.sv
// layer_seq: walks a host-written layer-descriptor table and drives batch_ctrl through
// weight load, bias load and batch execution per layer. Option macro: LAYER_SEQ_PERF_EN.
module layer_seq #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [95:0]   cfg_data,
    input  logic          start,
    input  logic          abort,
    input  logic          src_valid,
    input  logic          src_ready,
    input  logic          batch_fin,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [AW-1:0] layer,
    output logic          run,
    output logic          pool,
    output logic          wwrite,
    output logic          bwrite,
    output logic          backprop,
    output logic          deltaw,
    output logic          last,
    output logic [11:0]   ss,
    output logic [11:0]   ds,
    output logic [3:0]    id,
    output logic [3:0]    od,
    output logic [9:0]    fs,
    output logic [9:0]    ks
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]   perf_cyc
`endif
);

    typedef struct packed {
        logic        eol;
        logic        deltaw;
        logic        backprop;
        logic        pool;
        logic [11:0] nbatch;
        logic [11:0] bcnt;
        logic [11:0] wcnt;
        logic [9:0]  ks;
        logic [9:0]  fs;
        logic [3:0]  od;
        logic [3:0]  id;
        logic [11:0] ds;
        logic [11:0] ss;
    } desc_t;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WLD, S_WGAP, S_BLD, S_BGAP, S_EXEC, S_EGAP, S_FIN
    } state_t;

    state_t        r_state;
    desc_t         r_tbl [DEPTH];
    logic [11:0]   r_wcnt, r_bcnt, r_nb, r_cnt;
    logic          r_pool_sel, r_eol;
    logic          r_busy, r_done, r_cfg_err;
    logic          r_run, r_pool, r_wwrite, r_bwrite, r_backprop, r_deltaw, r_last;
    logic [AW-1:0] r_layer;
    logic [11:0]   r_ss, r_ds;
    logic [3:0]    r_id, r_od;
    logic [9:0]    r_fs, r_ks;

    desc_t       w_ent;
    logic        w_start, w_beat, w_load;
    logic [11:0] w_bc, w_nb;
    logic        w_pl, w_go_w, w_go_b, w_go_e;
    logic        w_unused;

    // bits above eol carry no meaning
    assign w_unused = &{1'b0, cfg_data[95:92]};

    assign w_ent   = r_tbl[r_layer];
    assign w_start = start && (r_state == S_IDLE) && !abort;
    assign w_beat  = src_valid && src_ready;
    assign w_load  = (r_state == S_LOAD);

    // LOAD decides from the table entry itself; the gaps from the latched copy
    assign w_bc   = w_load ? w_ent.bcnt   : r_bcnt;
    assign w_nb   = w_load ? w_ent.nbatch : r_nb;
    assign w_pl   = w_load ? w_ent.pool   : r_pool_sel;
    assign w_go_w = w_load && (w_ent.wcnt != 12'd0);
    assign w_go_b = (w_load || r_state == S_WGAP) && (w_bc != 12'd0);
    assign w_go_e = (w_nb != 12'd0);

    always_ff @(posedge clk) begin
        if (cfg_we && r_state == S_IDLE)
            r_tbl[cfg_addr] <= cfg_data[91:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wcnt     <= '0;
            r_bcnt     <= '0;
            r_nb       <= '0;
            r_cnt      <= '0;
            r_pool_sel <= 1'b0;
            r_eol      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_run      <= 1'b0;
            r_pool     <= 1'b0;
            r_wwrite   <= 1'b0;
            r_bwrite   <= 1'b0;
            r_backprop <= 1'b0;
            r_deltaw   <= 1'b0;
            r_last     <= 1'b0;
            r_layer    <= '0;
            r_ss       <= '0;
            r_ds       <= '0;
            r_id       <= '0;
            r_od       <= '0;
            r_fs       <= '0;
            r_ks       <= '0;
        end else begin
            if (cfg_we && r_busy)
                r_cfg_err <= 1'b1;
            else if (w_start)
                r_cfg_err <= 1'b0;

            if (abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
                r_layer  <= '0;
                r_run    <= 1'b0;
                r_pool   <= 1'b0;
                r_wwrite <= 1'b0;
                r_bwrite <= 1'b0;
                r_last   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_layer <= '0;
                    end
                    S_LOAD, S_WGAP, S_BGAP: begin
                        r_cnt <= '0;
                        if (w_load) begin
                            r_ss       <= w_ent.ss;
                            r_ds       <= w_ent.ds;
                            r_id       <= w_ent.id;
                            r_od       <= w_ent.od;
                            r_fs       <= w_ent.fs;
                            r_ks       <= w_ent.ks;
                            r_backprop <= w_ent.backprop;
                            r_deltaw   <= w_ent.deltaw;
                            r_wcnt     <= w_ent.wcnt;
                            r_bcnt     <= w_ent.bcnt;
                            r_nb       <= w_ent.nbatch;
                            r_pool_sel <= w_ent.pool;
                            r_eol      <= w_ent.eol;
                        end
                        if (w_go_w) begin
                            r_state  <= S_WLD;
                            r_wwrite <= 1'b1;
                        end else if (w_go_b) begin
                            r_state  <= S_BLD;
                            r_bwrite <= 1'b1;
                        end else if (w_go_e) begin
                            r_state <= S_EXEC;
                            r_run   <= !w_pl;
                            r_pool  <= w_pl;
                            r_last  <= (w_nb == 12'd1);
                        end else begin
                            r_state <= S_EGAP;
                        end
                    end
                    S_WLD: if (w_beat) begin
                        if (r_cnt == r_wcnt - 12'd1) begin
                            r_wwrite <= 1'b0;
                            r_state  <= S_WGAP;
                        end else begin
                            r_cnt <= r_cnt + 12'd1;
                        end
                    end
                    S_BLD: if (w_beat) begin
                        if (r_cnt == r_bcnt - 12'd1) begin
                            r_bwrite <= 1'b0;
                            r_state  <= S_BGAP;
                        end else begin
                            r_cnt <= r_cnt + 12'd1;
                        end
                    end
                    S_EXEC: if (batch_fin) begin
                        if (r_cnt == r_nb - 12'd1) begin
                            r_run   <= 1'b0;
                            r_pool  <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_EGAP;
                        end else begin
                            r_cnt  <= r_cnt + 12'd1;
                            r_last <= (r_cnt + 12'd2 == r_nb);
                        end
                    end
                    S_EGAP: begin
                        if (r_eol || r_layer == AW'(DEPTH - 1)) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_layer <= r_layer + AW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                    S_FIN: begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] r_perf;

    // busy spans exactly LOAD entry up to FIN
    always_ff @(posedge clk) begin
        if (rst || w_start)
            r_perf <= '0;
        else if (r_busy && r_perf != 32'hFFFF_FFFF)
            r_perf <= r_perf + 32'd1;
    end
    assign perf_cyc = r_perf;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;
    assign layer    = r_layer;
    assign run      = r_run;
    assign pool     = r_pool;
    assign wwrite   = r_wwrite;
    assign bwrite   = r_bwrite;
    assign backprop = r_backprop;
    assign deltaw   = r_deltaw;
    assign last     = r_last;
    assign ss       = r_ss;
    assign ds       = r_ds;
    assign id       = r_id;
    assign od       = r_od;
    assign fs       = r_fs;
    assign ks       = r_ks;

endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: phase-level scoreboard for layer_seq; each phase (constant mode/layer/ss)
// is recorded with its cycle, accepted-beat and batch_fin counts and compared in order.
module tb_layer_seq;

    localparam logic [6:0] FB = 7'h40, FD = 7'h20, FRUN = 7'h50, FPOOL = 7'h48;
    localparam logic [6:0] FWW = 7'h44, FBW = 7'h42, FLST = 7'h01;

    logic        clk = 1'b0, rst = 1'b1, cfg_we = 1'b0, start = 1'b0, abort = 1'b0;
    logic        src_valid = 1'b0, src_ready = 1'b0, batch_fin = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [95:0] cfg_data = '0;
    logic        busy, done, cfg_err, run, pool, wwrite, bwrite, backprop, deltaw, last;
    logic [2:0]  layer;
    logic [11:0] ss, ds;
    logic [3:0]  id, od;
    logic [9:0]  fs, ks;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_cyc;
`endif

    int nchk = 0, nfail = 0, busy_cyc = 0;
    logic [61:0] exp_q[$];

    layer_seq #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .abort(abort), .src_valid(src_valid), .src_ready(src_ready),
        .batch_fin(batch_fin), .busy(busy), .done(done), .cfg_err(cfg_err), .layer(layer),
        .run(run), .pool(pool), .wwrite(wwrite), .bwrite(bwrite), .backprop(backprop),
        .deltaw(deltaw), .last(last), .ss(ss), .ds(ds), .id(id), .od(od), .fs(fs), .ks(ks)
`ifdef LAYER_SEQ_PERF_EN
        , .perf_cyc(perf_cyc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [95:0] mkd(input logic [11:0] s, d, input logic [3:0] i, o,
                                        input logic [9:0] f, k, input logic [11:0] wc, bc, nb,
                                        input logic pl, bp, dw, eol);
        return {4'h0, eol, dw, bp, pl, nb, bc, wc, k, f, o, i, d, s};
    endfunction

    task automatic ex(input logic [6:0] fl, input logic [2:0] l, input logic [11:0] s,
                      input int c, input int b, input int n);
        exp_q.push_back({fl, l, s, 16'(c), 16'(b), 8'(n)});
    endtask

    // one layer {wcnt=4,bcnt=2,nbatch=3,eol}, source always ready, batch every 3 cycles
    task automatic exp_t1(input logic [11:0] pss);
        ex(FB, 0, pss, 1, 1, 0);
        ex(FWW, 0, 12'h0A1, 4, 4, 0);
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FBW, 0, 12'h0A1, 2, 2, 0);
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FRUN, 0, 12'h0A1, 6, 6, 2);
        ex(FRUN | FLST, 0, 12'h0A1, 3, 3, 1);
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FD, 0, 12'h0A1, 1, 1, 0);
    endtask

    // monitor: closes a phase record whenever the observed key changes
    logic [21:0] k, cur_k;
    int          cyc, bts, fns;
    bit          act = 1'b0;
    logic [61:0] e;
    always @(negedge clk) begin
        k = (busy || done) ? {busy, done, run, pool, wwrite, bwrite, last, layer, ss} : '0;
        if (act && k != cur_k) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL phase_extra: got %h expected none",
                         {cur_k, 16'(cyc), 16'(bts), 8'(fns)});
            end else begin
                e = exp_q.pop_front();
                chk("phase", {2'b0, cur_k, 16'(cyc), 16'(bts), 8'(fns)}, {2'b0, e});
            end
            act = 1'b0;
        end
        if (k != '0) begin
            if (!act) begin
                act = 1'b1;
                cur_k = k;
                cyc = 0;
                bts = 0;
                fns = 0;
            end
            cyc++;
            bts += int'(src_valid && src_ready);
            fns += int'(batch_fin);
        end
        if (busy) busy_cyc++;
    end

    // batch producer: one batch_fin every third cycle of run/pool
    int bcnt = 0;
    initial forever begin
        @(posedge clk); #1;
        if (run || pool) begin
            if (bcnt == 2) begin
                batch_fin = 1'b1;
                bcnt = 0;
            end else begin
                batch_fin = 1'b0;
                bcnt++;
            end
        end else begin
            batch_fin = 1'b0;
            bcnt = 0;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [95:0] d);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic go();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(nm, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [95:0] d1;
    int n;
    initial begin
        d1 = mkd(12'h0A1, 12'h0B2, 4'h3, 4'h4, 10'h015, 10'h02A, 12'd4, 12'd2, 12'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {busy, done, cfg_err, layer, run, pool, wwrite, bwrite, backprop, deltaw, last}, 0);
        chk("reset_size", {ss, ds, id, od, fs, ks}, 0);

        // basic single layer, beats every cycle
        src_valid = 1'b1;
        src_ready = 1'b1;
        wr(3'd0, d1);
        exp_t1(12'h000);
        busy_cyc = 0;
        go();
        wait_idle("t1_idle");
        chk("t1_size", {ds, id, od, fs, ks}, {12'h0B2, 4'h3, 4'h4, 10'h015, 10'h02A});
        chk("t1_bp_dw", {backprop, deltaw}, 2'b10);
`ifdef LAYER_SEQ_PERF_EN
        chk("perf_fin", perf_cyc, 64'(busy_cyc));
        repeat (3) @(posedge clk);
        chk("perf_hold", perf_cyc, 64'(busy_cyc));
`endif
        repeat (2) @(posedge clk);

        // src_ready toggling every cycle
        ex(FB, 0, 12'h0A1, 1, 0, 0);
        ex(FWW, 0, 12'h0A1, 7, 4, 0);
        ex(FB, 0, 12'h0A1, 1, 0, 0);
        ex(FBW, 0, 12'h0A1, 3, 2, 0);
        ex(FB, 0, 12'h0A1, 1, 0, 0);
        ex(FRUN, 0, 12'h0A1, 6, 3, 2);
        ex(FRUN | FLST, 0, 12'h0A1, 3, 2, 1);
        ex(FB, 0, 12'h0A1, 1, 0, 0);
        ex(FD, 0, 12'h0A1, 1, 1, 0);
        @(posedge clk); #1;
        start = 1'b1;
        src_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            src_ready = ~src_ready;
        end
        src_ready = 1'b1;
        wait_idle("t2_idle");
        repeat (2) @(posedge clk);

        // two layers: pool-only then run
        wr(3'd0, mkd(12'h111, 12'h011, 4'h1, 4'h1, 10'h1, 10'h1, 12'd0, 12'd0, 12'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        wr(3'd1, mkd(12'h222, 12'h022, 4'h2, 4'h2, 10'h2, 10'h2, 12'd0, 12'd0, 12'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FPOOL | FLST, 0, 12'h111, 3, 3, 1);
        ex(FB, 0, 12'h111, 1, 1, 0);
        ex(FB, 1, 12'h111, 1, 1, 0);
        ex(FRUN, 1, 12'h222, 3, 3, 1);
        ex(FRUN | FLST, 1, 12'h222, 3, 3, 1);
        ex(FB, 1, 12'h222, 1, 1, 0);
        ex(FD, 1, 12'h222, 1, 1, 0);
        go();
        wait_idle("t3_idle");
        repeat (2) @(posedge clk);

        // abort during the second batch
        wr(3'd0, d1);
        ex(FB, 0, 12'h222, 1, 1, 0);
        ex(FWW, 0, 12'h0A1, 4, 4, 0);
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FBW, 0, 12'h0A1, 2, 2, 0);
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        ex(FRUN, 0, 12'h0A1, 5, 5, 1);
        go();
        n = 0;
        while (!run && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_state", {busy, done, run, layer}, 0);
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort", busy, 0);

        // rerun with table write and start while busy; both must be ignored
        exp_t1(12'h0A1);
        go();
        n = 0;
        while (!wwrite && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        cfg_we = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = mkd(12'hFFF, 12'hFFF, 4'hF, 4'hF, 10'h3FF, 10'h3FF, 12'd1, 12'd0, 12'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("cfg_err_set", cfg_err, 1);
        wait_idle("t5a_idle");
        chk("cfg_err_sticky", cfg_err, 1);
        repeat (2) @(posedge clk);
        exp_t1(12'h0A1);
        go();
        @(negedge clk);
        chk("cfg_err_clr", cfg_err, 0);
        wait_idle("t5b_idle");
        repeat (2) @(posedge clk);

        // eight empty layers, no eol: stops at the last table entry
        for (int i = 0; i < 8; i++)
            wr(3'(i), mkd(12'h300 + 12'(i), 12'h0, 4'h0, 4'h0, 10'h0, 10'h0, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        ex(FB, 0, 12'h0A1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            ex(FB, 3'(i), 12'h300 + 12'(i), 1, 1, 0);
            if (i < 7) ex(FB, 3'(i + 1), 12'h300 + 12'(i), 1, 1, 0);
        end
        ex(FD, 7, 12'h307, 1, 1, 0);
        go();
        wait_idle("t6_idle");

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
